// File: rtl/fp_mant_divider_pkg.sv
// Shared FPU definitions for the significand divider and the rounder.
//   state_e      : divider FSM encoding
//   MANT_W_SP    : single-precision significand width (hidden bit included)
//   LGRS_*       : bit positions inside the packed {L, G, R, S} rounding field
package fp_mant_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned MANT_W_SP = 24;

   localparam int unsigned LGRS_W = 4;
   localparam int unsigned LGRS_L = 3;
   localparam int unsigned LGRS_G = 2;
   localparam int unsigned LGRS_R = 1;
   localparam int unsigned LGRS_S = 0;

endpackage

// File: rtl/fp_mant_divider.sv
// Iterative radix-2 restoring divider for normalized significands.
// Ports:
//   clk_i, reset_i (async, active-low)
//   start_i      : request, sampled in IDLE only
//   kill_i       : flush, forces IDLE and suppresses done_o
//   dividend_i   : significand a (MSB set)
//   divisor_i    : significand b (MSB set, or zero for divide-by-zero)
//   busy_o       : operation in flight (cycle after start through DONE)
//   done_o       : one-cycle result-valid pulse
//   quot_o       : normalized quotient significand
//   lgrs_o       : {L, G, R, S} rounding bits
//   exp_dec_o    : quotient was below 1.0, exponent must drop by one
//   div_zero_o   : divisor was zero
module fp_mant_divider
   import fp_mant_divider_pkg::*;
#(
   parameter int unsigned MANT_W = MANT_W_SP
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              kill_i,
   input  logic [MANT_W-1:0] dividend_i,
   input  logic [MANT_W-1:0] divisor_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [MANT_W-1:0] quot_o,
   output logic [LGRS_W-1:0] lgrs_o,
   output logic              exp_dec_o,
   output logic              div_zero_o
);

   localparam int unsigned REM_W = MANT_W + 2;
   localparam int unsigned Q_W   = MANT_W + 3;
   localparam int unsigned CNT_W = $clog2(MANT_W + 3);

   state_e              state_q, state_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [Q_W-1:0]      q_q, q_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MANT_W-1:0]   divisor_q, divisor_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [MANT_W-1:0]   quot_q, quot_d;
   logic [LGRS_W-1:0]   lgrs_q, lgrs_d;
   logic                exp_dec_q, exp_dec_d;
   logic                div_zero_q, div_zero_d;

   // One restoring step: the borrow of a single REM_W+1-bit subtract is the compare.
   logic [REM_W:0]      diff;
   logic                ge;
   logic [REM_W-1:0]    rem_step;
   logic [REM_W-1:0]    rem_shift;
   logic [Q_W-1:0]      q_step;

   always_comb begin
      diff      = {1'b0, rem_q} - {3'b000, divisor_q};
      ge        = ~diff[REM_W];
      rem_step  = ge ? diff[REM_W-1:0] : rem_q;
      rem_shift = REM_W'({rem_step, 1'b0});
      q_step    = {q_q[Q_W-2:0], ge};
   end

   // Normalization of the final quotient, evaluated on the last iteration.
   logic [MANT_W-1:0]   norm_quot;
   logic [LGRS_W-1:0]   norm_lgrs;
   logic                norm_exp_dec;
   logic                rem_nz;

   always_comb begin
      rem_nz    = |rem_shift;
      norm_lgrs = '0;
      if (q_step[Q_W-1]) begin
         norm_quot            = q_step[Q_W-1:3];
         norm_lgrs[LGRS_G]    = q_step[2];
         norm_lgrs[LGRS_R]    = q_step[1];
         norm_lgrs[LGRS_S]    = q_step[0] | rem_nz;
         norm_exp_dec         = 1'b0;
      end else begin
         norm_quot            = q_step[Q_W-2:2];
         norm_lgrs[LGRS_G]    = q_step[1];
         norm_lgrs[LGRS_R]    = q_step[0];
         norm_lgrs[LGRS_S]    = rem_nz;
         norm_exp_dec         = 1'b1;
      end
      norm_lgrs[LGRS_L] = norm_quot[0];
   end

   // Next-state and register updates; kill overrides everything and leaves results alone.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      q_d        = q_q;
      cnt_d      = cnt_q;
      divisor_d  = divisor_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      quot_d     = quot_q;
      lgrs_d     = lgrs_q;
      exp_dec_d  = exp_dec_q;
      div_zero_d = div_zero_q;

      if (kill_i) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  divisor_d = divisor_i;
                  rem_d     = {2'b00, dividend_i};
                  q_d       = '0;
                  cnt_d     = CNT_W'(MANT_W + 2);
                  busy_d    = 1'b1;
                  if (divisor_i == '0) begin
                     state_d    = ST_DONE;
                     done_d     = 1'b1;
                     quot_d     = '0;
                     lgrs_d     = '0;
                     exp_dec_d  = 1'b0;
                     div_zero_d = 1'b1;
                  end else begin
                     state_d = ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               rem_d = rem_shift;
               q_d   = q_step;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  quot_d     = norm_quot;
                  lgrs_d     = norm_lgrs;
                  exp_dec_d  = norm_exp_dec;
                  div_zero_d = 1'b0;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         divisor_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quot_q     <= '0;
         lgrs_q     <= '0;
         exp_dec_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         q_q        <= q_d;
         cnt_q      <= cnt_d;
         divisor_q  <= divisor_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quot_q     <= quot_d;
         lgrs_q     <= lgrs_d;
         exp_dec_q  <= exp_dec_d;
         div_zero_q <= div_zero_d;
      end
   end

   // A flush arriving in the DONE cycle still has to hide the pulse.
   assign done_o     = done_q & ~kill_i;
   assign busy_o     = busy_q;
   assign quot_o     = quot_q;
   assign lgrs_o     = lgrs_q;
   assign exp_dec_o  = exp_dec_q;
   assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_fp_mant_divider.sv
// Self-checking bench for fp_mant_divider: directed vectors plus randomized
// operations against an arithmetic reference model.
module tb_fp_mant_divider;

   localparam int unsigned MANT_W = 24;
   localparam int unsigned RES_W  = MANT_W + 6;

   logic              clk_i = 1'b0;
   logic              reset_i = 1'b0;
   logic              start_i = 1'b0;
   logic              kill_i = 1'b0;
   logic [MANT_W-1:0] dividend_i = '0;
   logic [MANT_W-1:0] divisor_i = '0;
   logic              busy_o;
   logic              done_o;
   logic [MANT_W-1:0] quot_o;
   logic [3:0]        lgrs_o;
   logic              exp_dec_o;
   logic              div_zero_o;

   int checks = 0;
   int errors = 0;

   fp_mant_divider #(.MANT_W(MANT_W)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .kill_i     (kill_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .quot_o     (quot_o),
      .lgrs_o     (lgrs_o),
      .exp_dec_o  (exp_dec_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result word {quot, L, G, R, S, exp_dec, div_zero} from plain integer division.
   function automatic logic [RES_W-1:0] ref_div(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
      longint unsigned num, q, r, quot, g, rr, s, l, ed;
      if (b == '0) return {{MANT_W{1'b0}}, 4'b0000, 1'b0, 1'b1};
      num = longint'(a) << (MANT_W + 2);
      q   = num / longint'(b);
      r   = num % longint'(b);
      if (((q >> (MANT_W + 2)) & 1) != 0) begin
         quot = q >> 3;
         g = (q >> 2) & 1; rr = (q >> 1) & 1; s = ((q & 1) != 0 || r != 0) ? 1 : 0;
         ed = 0;
      end else begin
         quot = q >> 2;
         g = (q >> 1) & 1; rr = q & 1; s = (r != 0) ? 1 : 0;
         ed = 1;
      end
      l = quot & 1;
      return {MANT_W'(quot), 1'(l), 1'(g), 1'(rr), 1'(s), 1'(ed), 1'b0};
   endfunction

   // Transaction-level model: latency and visible result word.
   logic             m_busy = 1'b0;
   logic             m_done = 1'b0;
   int               m_left = 0;
   logic [RES_W-1:0] m_pend = '0;
   logic [RES_W-1:0] m_out  = '0;

   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_out = '0; m_pend = '0;
      end else if (kill_i) begin
         m_busy = 1'b0; m_done = 1'b0;
      end else if (m_done) begin
         m_busy = 1'b0; m_done = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_out  = m_pend;
         end
      end else if (start_i) begin
         m_busy = 1'b1;
         m_pend = ref_div(dividend_i, divisor_i);
         if (divisor_i == '0) begin
            m_done = 1'b1;
            m_out  = m_pend;
         end else begin
            m_left = MANT_W + 3;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk_i) begin
      chk("cycle_outputs",
          64'({busy_o, done_o, quot_o, lgrs_o, exp_dec_o, div_zero_o}),
          64'({m_busy, m_done & ~kill_i, m_out}));
   end

   // Issue one start; optionally inject a stray start, a kill or a reset at a given cycle.
   task automatic run_op(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                         input int ign_at, input int kill_at, input int rst_at,
                         output int done_n, output logic [31:0] snap, output logic busy_after_kill);
      done_n = 0;
      snap = '0;
      busy_after_kill = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b1; dividend_i = a; divisor_i = b;
      for (int n = 1; n <= 32; n++) begin
         @(posedge clk_i); #1;
         start_i = 1'b0; kill_i = 1'b0;
         if (n == ign_at) begin
            start_i = 1'b1;
            dividend_i = {1'b1, 23'($urandom)};
            divisor_i  = {1'b1, 23'($urandom)};
         end
         if (n == kill_at) kill_i = 1'b1;
         if (n == rst_at) reset_i = 1'b0;
         if (n == rst_at + 2) reset_i = 1'b1;
         @(negedge clk_i);
         if (n == rst_at) snap = {busy_o, done_o, quot_o, lgrs_o, exp_dec_o, div_zero_o};
         if (n == kill_at + 1) busy_after_kill = busy_o;
         if (done_o && done_n == 0) done_n = n;
         if (done_n != 0) break;
      end
      start_i = 1'b0; kill_i = 1'b0; reset_i = 1'b1;
   endtask

   int          dn;
   logic [31:0] snap;
   logic        bak;
   logic [MANT_W-1:0] prev_q;

   initial begin
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_outputs", 64'({busy_o, done_o, quot_o, lgrs_o, exp_dec_o, div_zero_o}), 64'd0);
      #1 reset_i = 1'b1;

      chk("model_pin_1_1",  64'(ref_div(24'h800000, 24'h800000)), 64'({24'h800000, 4'b0000, 1'b0, 1'b0}));
      chk("model_pin_2_3",  64'(ref_div(24'h800000, 24'hC00000)), 64'({24'hAAAAAA, 4'b0101, 1'b1, 1'b0}));
      chk("model_pin_max",  64'(ref_div(24'hFFFFFF, 24'h800000)), 64'({24'hFFFFFF, 4'b1000, 1'b0, 1'b0}));
      chk("model_pin_dz",   64'(ref_div(24'hC00000, 24'h000000)), 64'({24'h000000, 4'b0000, 1'b0, 1'b1}));

      run_op(24'h800000, 24'h800000, 0, 0, 0, dn, snap, bak);
      chk("one_done_cycle", 64'(dn), 64'd28);
      chk("one_quot", 64'(quot_o), 64'h800000);
      chk("one_lgrs", 64'(lgrs_o), 64'h0);
      chk("one_exp_dec", 64'(exp_dec_o), 64'h0);

      run_op(24'h800000, 24'hC00000, 0, 0, 0, dn, snap, bak);
      chk("two_thirds_quot", 64'(quot_o), 64'hAAAAAA);
      chk("two_thirds_lgrs", 64'(lgrs_o), 64'h5);
      chk("two_thirds_exp_dec", 64'(exp_dec_o), 64'h1);

      run_op(24'hFFFFFF, 24'h800000, 0, 0, 0, dn, snap, bak);
      chk("max_quot", 64'(quot_o), 64'hFFFFFF);
      chk("max_lgrs", 64'(lgrs_o), 64'h8);
      chk("max_exp_dec", 64'(exp_dec_o), 64'h0);

      run_op(24'hC00000, 24'h000000, 0, 0, 0, dn, snap, bak);
      chk("dz_done_cycle", 64'(dn), 64'd1);
      chk("dz_flag", 64'(div_zero_o), 64'h1);
      chk("dz_quot", 64'(quot_o), 64'h0);

      run_op(24'h800000, 24'hC00000, 10, 0, 0, dn, snap, bak);
      chk("ignored_start_done_cycle", 64'(dn), 64'd28);
      chk("ignored_start_quot", 64'(quot_o), 64'hAAAAAA);

      prev_q = quot_o;
      run_op(24'hFFFFFF, 24'h800000, 0, 15, 0, dn, snap, bak);
      chk("kill_no_done", 64'(dn), 64'd0);
      chk("kill_busy_next", 64'(bak), 64'd0);
      chk("kill_quot_held", 64'(quot_o), 64'(prev_q));

      run_op(24'hFFFFFF, 24'h800000, 0, 0, 12, dn, snap, bak);
      chk("reset_mid_op_outputs", 64'(snap), 64'd0);
      chk("reset_mid_op_no_done", 64'(dn), 64'd0);

      run_op(24'hC00000, 24'h800000, 0, 0, 0, dn, snap, bak);
      chk("post_reset_done_cycle", 64'(dn), 64'd28);
      chk("post_reset_quot", 64'(quot_o), 64'hC00000);
      chk("post_reset_lgrs", 64'(lgrs_o), 64'h0);

      for (int i = 0; i < 200; i++) begin
         logic [MANT_W-1:0] a, b;
         int k, g;
         a = {1'b1, 23'($urandom)};
         b = ($urandom_range(0, 15) == 0) ? '0 : {1'b1, 23'($urandom)};
         k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : 0;
         g = (k == 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 27)) : 0;
         run_op(a, b, g, k, 0, dn, snap, bak);
      end

      repeat (3) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_mant_divider.md
# fp_mant_divider

Iterative radix-2 restoring divider for the FPU division path. It divides two normalized significands (hidden bit included) and produces a normalized quotient significand, a one-bit exponent decrement, and the packed LGRS bits that the division rounding stage consumes. Sign, exponent and special-operand handling stay outside this block; it sits between operand unpacking and the rounder/packer.

## Interface

Parameters:
- MANT_W, default 24: significand width, hidden bit included; 24 for single precision.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- kill_i  in  1  flush; aborts any operation in progress.
- dividend_i  in  MANT_W  significand a, MSB = 1 expected.
- divisor_i  in  MANT_W  significand b, MSB = 1 expected.
- busy_o  out  1  high from the cycle after an accepted start through the DONE cycle.
- done_o  out  1  one-cycle pulse; all result outputs are valid.
- quot_o  out  MANT_W  normalized quotient significand, MSB = 1 unless div_zero_o.
- lgrs_o  out  4  {L, G, R, S} for the rounder.
- exp_dec_o  out  1  1 = quotient was below 1.0; the exponent path subtracts one.
- div_zero_o  out  1  divisor_i was all-zero.

## Operation

- FSM states: IDLE, ITER, DONE.
- IDLE:
  - start_i = 1 latches the operands.
  - rem (MANT_W+2 bits) = {2'b0, dividend_i}; iteration counter = MANT_W+2.
  - Go to ITER. If divisor_i == 0, go to DONE instead with div_zero_o = 1.
- ITER, once per cycle:
  - If rem >= divisor: shift in quotient bit 1, rem = (rem - divisor) << 1.
  - Otherwise: shift in 0, rem = rem << 1.
  - Decrement the counter. After MANT_W+3 iterations, go to DONE.
- Quotient q has MANT_W+3 bits; q[MANT_W+2] has weight 2^0. q lies in (0.5, 2).
- Normalization in DONE, with N = MANT_W:
  - If q[N+2] = 1: quot = q[N+2:3], G = q[2], R = q[1], S = q[0] | (rem != 0), exp_dec = 0.
  - Else: quot = q[N+1:2], G = q[1], R = q[0], S = (rem != 0), exp_dec = 1.
  - L = quot[0].
- Divide-by-zero result: quot_o = 0, lgrs_o = 0, exp_dec_o = 0, div_zero_o = 1. The caller forms infinity.
- Result outputs are registered. They hold their value until the next accepted start, and are not cleared by DONE → IDLE.
- start_i outside IDLE is ignored, with no queuing.
- kill_i:
  - Forces IDLE on the next edge from any state.
  - Suppresses done_o, including when kill_i coincides with the DONE cycle.
  - Result outputs keep their previous values.
  - kill_i with start_i in IDLE: kill wins and the start is dropped.

## Timing

- Reset values: FSM = IDLE, busy_o = 0, done_o = 0, quot_o = 0, lgrs_o = 0, exp_dec_o = 0, div_zero_o = 0; internal rem, q and counter = 0.
- Reset asserted mid-operation aborts immediately and asynchronously; no done_o is produced.
- Start sampled at edge 0. ITER occupies cycles 1..MANT_W+3, which is 27 cycles for MANT_W = 24. DONE and done_o occur in cycle MANT_W+4 (cycle 28), then the FSM returns to IDLE.
- Earliest next start: the cycle after DONE. Throughput is one operation per MANT_W+5 cycles.
- Divide-by-zero: done_o in cycle 1.
- The subtract/compare is a single MANT_W+2-bit adder per cycle. There is no other arithmetic on the critical path.

## Structure

- Shared FPU package:
  - FSM state encoding.
  - MANT_W default for single precision.
  - LGRS bit-index constants (L = 3, G = 2, R = 1, S = 0), shared with the rounder.
- Single module; no sub-module. The normalization mux is inline combinational logic feeding the DONE registers.

## Test plan

- 0x800000 / 0x800000, start pulse → done_o exactly in cycle 28; quot_o = 0x800000, lgrs_o = 4'b0000, exp_dec_o = 0, busy_o high in cycles 1–28.
- 0x800000 / 0xC00000 → quot_o = 0xAAAAAA, lgrs_o = 4'b0101, exp_dec_o = 1.
- 0xFFFFFF / 0x800000 → quot_o = 0xFFFFFF, lgrs_o = 4'b1000, exp_dec_o = 0.
- divisor_i = 0 with dividend_i = 0xC00000 → done_o in cycle 1, div_zero_o = 1, quot_o = 0.
- Second start_i at cycle 10 with different operands → ignored; result still matches the first operation at cycle 28. kill_i at cycle 15 of a new operation → no done_o, busy_o low next cycle, outputs unchanged.
- reset_i low at cycle 12 → all outputs zero immediately. After release, a fresh 0xC00000 / 0x800000 gives quot_o = 0xC00000, lgrs_o = 0, done_o at cycle 28.
